// File: rtl/lsu.sv
// Load/store unit: accepts one RISC-V load/store at a time, drives a byte-addressed
// data memory, and returns a sign/zero-extended load result or an alignment error.
module lsu #(
  parameter int unsigned ADDR_BITWIDTH = 10
) (
  input  logic                     LSU_Clk,
  input  logic                     LSU_Reset_n,
  input  logic                     LSU_Req_Valid,
  output logic                     LSU_Req_Ready,
  input  logic                     LSU_Req_We,
  input  logic [2:0]               LSU_Req_Funct3,
  input  logic [31:0]              LSU_Req_Addr,
  input  logic [31:0]              LSU_Req_Wdata,
  output logic                     LSU_Rsp_Valid,
  output logic [31:0]              LSU_Rsp_Rdata,
  output logic                     LSU_Rsp_Error,
  output logic                     LSU_Mem_We,
  output logic                     LSU_Mem_Re,
  output logic [3:0]               LSU_Mem_Byteenable,
  output logic [ADDR_BITWIDTH-1:0] LSU_Mem_Address,
  output logic [31:0]              LSU_Mem_Data_Out,
  input  logic [31:0]              LSU_Mem_Data_In
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state;
  logic              lat_we;
  logic [F3_W-1:0]   lat_funct3;

  logic [BE_W-1:0]   req_be_c;
  logic              req_err_c;
  logic [DATA_W-1:0] load_ext_c;

  // Address bits above the memory window are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^LSU_Req_Addr[31:ADDR_BITWIDTH];

  // Size decode and legality check of the incoming request.
  always_comb begin
    req_be_c  = '0;
    req_err_c = 1'b0;
    case (LSU_Req_Funct3[1:0])
      2'b00: req_be_c = 4'b0001;
      2'b01: begin
        req_be_c  = 4'b0011;
        req_err_c = LSU_Req_Addr[0];
      end
      2'b10: begin
        req_be_c  = 4'b1111;
        req_err_c = (LSU_Req_Addr[1:0] != 2'b00);
      end
      default: req_err_c = 1'b1;
    endcase
    // Unsigned variants exist only for B/H loads.
    if (LSU_Req_Funct3[2] && (LSU_Req_We || LSU_Req_Funct3[1]))
      req_err_c = 1'b1;
  end

  // Extension of the returned read data according to the latched access type.
  always_comb begin
    load_ext_c = LSU_Mem_Data_In;
    case (lat_funct3)
      3'b000:  load_ext_c = {{24{LSU_Mem_Data_In[7]}},  LSU_Mem_Data_In[7:0]};
      3'b001:  load_ext_c = {{16{LSU_Mem_Data_In[15]}}, LSU_Mem_Data_In[15:0]};
      3'b100:  load_ext_c = {24'd0, LSU_Mem_Data_In[7:0]};
      3'b101:  load_ext_c = {16'd0, LSU_Mem_Data_In[15:0]};
      default: load_ext_c = LSU_Mem_Data_In;
    endcase
  end

  // Control FSM with registered memory and response outputs; Mem_Address doubles
  // as the latched request address while an access is in flight.
  always_ff @(posedge LSU_Clk or negedge LSU_Reset_n) begin
    if (!LSU_Reset_n) begin
      state              <= IDLE;
      lat_we             <= 1'b0;
      lat_funct3         <= '0;
      LSU_Req_Ready      <= 1'b1;
      LSU_Rsp_Valid      <= 1'b0;
      LSU_Rsp_Rdata      <= '0;
      LSU_Rsp_Error      <= 1'b0;
      LSU_Mem_We         <= 1'b0;
      LSU_Mem_Re         <= 1'b0;
      LSU_Mem_Byteenable <= '0;
      LSU_Mem_Address    <= '0;
      LSU_Mem_Data_Out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (LSU_Req_Valid) begin
            LSU_Req_Ready <= 1'b0;
            lat_we        <= LSU_Req_We;
            lat_funct3    <= LSU_Req_Funct3;
            if (req_err_c) begin
              state         <= RESP;
              LSU_Rsp_Valid <= 1'b1;
              LSU_Rsp_Rdata <= '0;
              LSU_Rsp_Error <= 1'b1;
            end else begin
              state              <= ISSUE;
              LSU_Mem_We         <= LSU_Req_We;
              LSU_Mem_Re         <= !LSU_Req_We;
              LSU_Mem_Byteenable <= req_be_c;
              LSU_Mem_Address    <= LSU_Req_Addr[ADDR_BITWIDTH-1:0];
              LSU_Mem_Data_Out   <= LSU_Req_Wdata;
            end
          end
        end
        ISSUE: begin
          if (lat_we) begin
            state              <= RESP;
            LSU_Rsp_Valid      <= 1'b1;
            LSU_Rsp_Rdata      <= '0;
            LSU_Rsp_Error      <= 1'b0;
            LSU_Mem_We         <= 1'b0;
            LSU_Mem_Re         <= 1'b0;
            LSU_Mem_Byteenable <= '0;
            LSU_Mem_Address    <= '0;
            LSU_Mem_Data_Out   <= '0;
          end else begin
            state      <= WAIT;
            LSU_Mem_We <= 1'b0;
            LSU_Mem_Re <= 1'b1;
          end
        end
        WAIT: begin
          state              <= RESP;
          LSU_Rsp_Valid      <= 1'b1;
          LSU_Rsp_Rdata      <= load_ext_c;
          LSU_Rsp_Error      <= 1'b0;
          LSU_Mem_We         <= 1'b0;
          LSU_Mem_Re         <= 1'b0;
          LSU_Mem_Byteenable <= '0;
          LSU_Mem_Address    <= '0;
          LSU_Mem_Data_Out   <= '0;
        end
        RESP: begin
          state         <= IDLE;
          LSU_Req_Ready <= 1'b1;
          LSU_Rsp_Valid <= 1'b0;
          LSU_Rsp_Rdata <= '0;
          LSU_Rsp_Error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: byte-addressed memory model, hand-computed load results,
// latency/error/backpressure checks and reset abort of an in-flight store.
module tb_lsu;

  localparam int unsigned AW = 10;
  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          mem_we;
  logic          mem_re;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_clr;

  int n_vec;
  int n_err;

  lsu #(.ADDR_BITWIDTH(AW)) dut (
    .LSU_Clk            (clk),
    .LSU_Reset_n        (rst_n),
    .LSU_Req_Valid      (req_valid),
    .LSU_Req_Ready      (req_ready),
    .LSU_Req_We         (req_we),
    .LSU_Req_Funct3     (req_funct3),
    .LSU_Req_Addr       (req_addr),
    .LSU_Req_Wdata      (req_wdata),
    .LSU_Rsp_Valid      (rsp_valid),
    .LSU_Rsp_Rdata      (rsp_rdata),
    .LSU_Rsp_Error      (rsp_error),
    .LSU_Mem_We         (mem_we),
    .LSU_Mem_Re         (mem_re),
    .LSU_Mem_Byteenable (mem_be),
    .LSU_Mem_Address    (mem_address),
    .LSU_Mem_Data_Out   (mem_wdata),
    .LSU_Mem_Data_In    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-addressed little-endian memory; read data registered one clock after the read edge.
  logic [7:0] mem [0:(1<<AW)-1];

  function automatic logic [31:0] mem_read(input logic [AW-1:0] a, input logic [3:0] be);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      logic [AW-1:0] ai;
      ai = a + AW'(i);
      if (be[i]) r[8*i +: 8] = mem[ai];
    end
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= 8'h00;
      mem_rdata <= '0;
    end else begin
      if (mem_we)
        for (int i = 0; i < 4; i++)
          if (mem_be[i]) mem[mem_address + AW'(i)] <= mem_wdata[8*i +: 8];
      if (mem_re) mem_rdata <= mem_read(mem_address, mem_be);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One request: drive at negedge, accept on next posedge, watch for the response pulse.
  task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_er, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        act;
    @(negedge clk);
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    lat = 0;
    act = 1'b0;
    rd  = '0;
    er  = 1'b0;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_we || mem_re) act = 1'b1;
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_error;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_error"}, 32'(er), 32'(exp_er));
    check({tag, "_memact"}, 32'(act), 32'(!exp_er));
    @(negedge clk);
    check({tag, "_pulse"}, 32'({rsp_valid, req_ready}), 32'b01);
  endtask

  initial begin
    logic [7:0] rdy_tr;
    logic [7:0] rv_tr;
    logic       saw_rsp;
    n_vec      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    mem_clr    = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = '0;
    req_wdata  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp", {rsp_valid, rsp_error, rsp_rdata[29:0]}, 32'd0);
    check("rst_mem_ctl", 32'({mem_we, mem_re, mem_be}), 32'd0);
    check("rst_mem_addr", 32'(mem_address), 32'd0);
    check("rst_mem_data", mem_wdata, 32'd0);
    rst_n   = 1'b1;
    mem_clr = 1'b0;

    xact("sw4",    1'b1, F_W,  32'h004, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    xact("lw4",    1'b0, F_W,  32'h004, 32'h0,        32'hDEADBEEF, 1'b0, 3);
    xact("sb7",    1'b1, F_B,  32'h007, 32'h00000080, 32'h0,        1'b0, 2);
    xact("lb7",    1'b0, F_B,  32'h007, 32'h0,        32'hFFFFFF80, 1'b0, 3);
    xact("lbu7",   1'b0, F_BU, 32'h007, 32'h0,        32'h00000080, 1'b0, 3);
    xact("lw4b",   1'b0, F_W,  32'h004, 32'h0,        32'h80ADBEEF, 1'b0, 3);
    xact("sh10",   1'b1, F_H,  32'h00A, 32'h00008001, 32'h0,        1'b0, 2);
    xact("lh10",   1'b0, F_H,  32'h00A, 32'h0,        32'hFFFF8001, 1'b0, 3);
    xact("lhu10",  1'b0, F_HU, 32'h00A, 32'h0,        32'h00008001, 1'b0, 3);
    xact("lw8",    1'b0, F_W,  32'h008, 32'h0,        32'h80010000, 1'b0, 3);
    xact("lw_mis", 1'b0, F_W,  32'h006, 32'h0,        32'h0,        1'b1, 1);
    xact("sh_mis", 1'b1, F_H,  32'h003, 32'h0000BEEF, 32'h0,        1'b1, 1);
    xact("sbu_il", 1'b1, F_BU, 32'h000, 32'h000000FF, 32'h0,        1'b1, 1);
    xact("f3_011", 1'b0, 3'b011, 32'h000, 32'h0,      32'h0,        1'b1, 1);
    xact("lw0",    1'b0, F_W,  32'h000, 32'h0,        32'h00000000, 1'b0, 3);
    xact("lw4c",   1'b0, F_W,  32'h004, 32'h0,        32'h80ADBEEF, 1'b0, 3);
    xact("lwwrap", 1'b0, F_W,  32'hFFFFF404, 32'h0,   32'h80ADBEEF, 1'b0, 3);

    // Valid held high: second accept only after RESP returns to IDLE.
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = F_BU;
    req_addr   = 32'h004;
    rdy_tr = '0;
    rv_tr  = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      rdy_tr[c] = req_ready;
      rv_tr[c]  = rsp_valid;
      if (c == 7) req_valid = 1'b0;
    end
    check("hold_ready_trace", 32'(rdy_tr), 32'h88);
    check("hold_rsp_trace", 32'(rv_tr), 32'h44);
    @(negedge clk);
    check("hold_no_third", 32'({req_ready, mem_re}), 32'b10);

    // Store a known value, then abort an overwriting store with reset during ISSUE.
    xact("sw10",   1'b1, F_W,  32'h010, 32'hCAFEF00D, 32'h0,        1'b0, 2);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F_W;
    req_addr   = 32'h010;
    req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    check("abort_issue_we", 32'(mem_we), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_mem_ctl", 32'({mem_we, mem_re, mem_be}), 32'd0);
    check("abort_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    saw_rsp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1'b1;
    end
    check("abort_no_rsp", 32'(saw_rsp), 32'd0);
    xact("lw10",   1'b0, F_W,  32'h010, 32'h0,        32'hCAFEF00D, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: LSU

Interface
REQ-001 SHALL have parameter ADDR_BITWIDTH, default 10, meaning the byte-address width driven to the data memory.
REQ-002 SHALL have port LSU_Clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port LSU_Reset_n, input, 1 bit, reset; asynchronous and active-low.
REQ-004 SHALL have port LSU_Req_Valid, input, 1 bit, pipeline request present.
REQ-005 SHALL have port LSU_Req_Ready, output, 1 bit, LSU can accept a request.
REQ-006 SHALL have port LSU_Req_We, input, 1 bit, 1 = store, 0 = load.
REQ-007 SHALL have port LSU_Req_Funct3, input, 3 bits, RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 SHALL have port LSU_Req_Addr, input, 32 bits, effective byte address.
REQ-009 SHALL have port LSU_Req_Wdata, input, 32 bits, store data, right-aligned.
REQ-010 SHALL have port LSU_Rsp_Valid, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port LSU_Rsp_Rdata, output, 32 bits, extended load result.
REQ-012 SHALL have port LSU_Rsp_Error, output, 1 bit, misaligned or illegal access, valid with LSU_Rsp_Valid.
REQ-013 SHALL have port LSU_Mem_We, output, 1 bit, memory write enable.
REQ-014 SHALL have port LSU_Mem_Re, output, 1 bit, memory read enable.
REQ-015 SHALL have port LSU_Mem_Byteenable, output, 4 bits, access size code (0001 byte, 0011 half, 1111 word).
REQ-016 SHALL have port LSU_Mem_Address, output, ADDR_BITWIDTH bits, memory byte address.
REQ-017 SHALL have port LSU_Mem_Data_Out, output, 32 bits, write data to memory.
REQ-018 SHALL have port LSU_Mem_Data_In, input, 32 bits, zero-extended read data from memory, valid one clock after the read edge while address and byteenable are held.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; LSU_Req_Ready = 1 only in IDLE.
REQ-020 SHALL accept a request on an edge where state is IDLE and LSU_Req_Valid = 1, and latch We, Funct3, Addr[ADDR_BITWIDTH-1:0], Wdata; request inputs outside that edge are ignored.
REQ-021 SHALL classify the latched access as error on: Funct3 in {011, 110, 111}, store with Funct3[2] = 1, half access with Addr[0] = 1, or word access with Addr[1:0] != 00.
REQ-022 SHALL go IDLE->RESP on an error access, with no memory enables asserted, Rdata = 0, and Error = 1.
REQ-023 SHALL go IDLE->ISSUE on a legal access.
REQ-024 SHALL, in ISSUE, drive Mem_Address = latched address, Mem_Byteenable per size, Mem_Data_Out = latched Wdata, and Mem_We = 1 for stores or Mem_Re = 1 for loads.
REQ-025 SHALL transition ISSUE->RESP for a store, the write completing on the ISSUE->RESP edge.
REQ-026 SHALL transition ISSUE->WAIT for a load.
REQ-027 SHALL, in WAIT, hold Mem_Address, Mem_Byteenable and Mem_Re = 1, with Mem_We = 0.
REQ-028 SHALL capture LSU_Mem_Data_In on the WAIT->RESP edge, extended as follows: B sign-extends bit 7; H sign-extends bit 15; BU/HU zero-extend; W passes through.
REQ-029 SHALL assert LSU_Rsp_Valid = 1 for exactly the RESP cycle; Rdata is 0 for stores; Error is 0 on legal accesses; RESP->IDLE unconditionally, with no response backpressure.
REQ-030 SHALL meet these latencies from the accept edge: store Rsp_Valid 2 cycles later, load 3 cycles later, error 1 cycle later; throughput is at most one request per latency+1 cycles.
REQ-031 SHALL drive Mem_We = 0, Mem_Re = 0, Mem_Byteenable = 0000, Mem_Address = 0 and Mem_Data_Out = 0 outside ISSUE and WAIT.
REQ-032 SHALL ignore address bits at and above ADDR_BITWIDTH; addresses wrap modulo 2**ADDR_BITWIDTH.

Reset
REQ-033 SHALL, while LSU_Reset_n = 0, force state IDLE, all latched registers to 0, Req_Ready = 1, Rsp_Valid = 0, Rsp_Rdata = 0, Rsp_Error = 0, and all Mem_* outputs to 0, independent of the clock.
REQ-034 SHALL, on reset asserted in ISSUE or WAIT, drop Mem_We/Mem_Re immediately so that no write occurs, produce no response for the aborted request, and accept a new request on the first edge after release.

Verification
REQ-035 SHALL cover: SW addr 0x004 data 0xDEADBEEF, then LW 0x004 -> Rdata 0xDEADBEEF, Error 0, load Rsp_Valid 3 cycles after accept.
REQ-036 SHALL cover: SB 0x80 to addr 0x007, then LB 0x007 -> 0xFFFFFF80; LBU 0x007 -> 0x00000080; LW 0x004 -> 0x80ADBEEF.
REQ-037 SHALL cover: SH 0x8001 to addr 0x00A, then LH 0x00A -> 0xFFFF8001; LHU 0x00A -> 0x00008001.
REQ-038 SHALL cover: LW addr 0x006 and SH addr 0x003 -> Error 1, Rdata 0, Rsp_Valid 1 cycle after accept, Mem_We/Mem_Re never high, memory unchanged.
REQ-039 SHALL cover: Req_Valid held high continuously -> second request accepted only after RESP, Req_Ready low in ISSUE/WAIT/RESP.
REQ-040 SHALL cover: reset pulsed during ISSUE of SW 0x12345678 to 0x010 -> no Rsp_Valid, subsequent LW 0x010 -> previous value, and Req_Ready = 1 after release.
